wb_to_ahbl_bridge: RTL

Wishbone-classic slave to AHB-Lite master bridge. It sits directly upstream of the 256x32 DFFRAM AHB-Lite wrapper and drives its HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA inputs. Each Wishbone cycle becomes one or more single, non-pipelined AHB transfers. Non-contiguous byte selects are split into sequential byte writes.

---
 rtl/wb_ahbl_pkg.sv | 18 +
 rtl/ahbl_sel_decode.sv | 48 ++++
 rtl/wb_to_ahbl_bridge.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/wb_ahbl_pkg.sv
// Shared AHB-Lite encodings and bridge FSM states for the Wishbone/AHB bridges.
package wb_ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_ACK  = 2'b11
  } state_e;

endpackage

// File: rtl/ahbl_sel_decode.sv
// Maps a pending byte-lane mask to the next AHB beat: size, low address bits and lanes consumed.
module ahbl_sel_decode
  import wb_ahbl_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic [3:0] mask_i,
  output logic [2:0] hsize_o,
  output logic [1:0] addr_lo_o,
  output logic [3:0] consumed_o
);

  always_comb begin
    hsize_o    = HSIZE_WORD;
    addr_lo_o  = 2'b00;
    consumed_o = 4'b1111;
    if (mask_i == 4'b1111) begin
      hsize_o = HSIZE_WORD;
    end else if (mask_i == 4'b0011 || (SPLIT_EN && mask_i[1:0] == 2'b11)) begin
      // The lower aligned half goes first when it is fully selected.
      hsize_o    = HSIZE_HALF;
      addr_lo_o  = 2'b00;
      consumed_o = 4'b0011;
    end else if (mask_i == 4'b1100) begin
      hsize_o    = HSIZE_HALF;
      addr_lo_o  = 2'b10;
      consumed_o = 4'b1100;
    end else if (SPLIT_EN || $onehot(mask_i)) begin
      hsize_o = HSIZE_BYTE;
      if (mask_i[0]) begin
        addr_lo_o  = 2'b00;
        consumed_o = 4'b0001;
      end else if (mask_i[1]) begin
        addr_lo_o  = 2'b01;
        consumed_o = 4'b0010;
      end else if (mask_i[2]) begin
        addr_lo_o  = 2'b10;
        consumed_o = 4'b0100;
      end else if (mask_i[3]) begin
        addr_lo_o  = 2'b11;
        consumed_o = 4'b1000;
      end else begin
        hsize_o = HSIZE_WORD;
      end
    end
  end

endmodule

// File: rtl/wb_to_ahbl_bridge.sv
// Wishbone-classic slave to AHB-Lite master; one or more single non-pipelined beats per cycle.
module wb_to_ahbl_bridge
  import wb_ahbl_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter bit          SPLIT_EN = 1'b1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          HSEL,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic [31:0]   HRDATA
);

  state_e        state_q, state_d;
  logic [AW-1:2] adr_q, adr_d;
  logic          we_q, we_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    mask_q, mask_d;
  logic          abort_q, abort_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          ack_q, ack_d;

  logic [2:0] dec_hsize;
  logic [1:0] dec_lo;
  logic [3:0] dec_consumed;
  logic [3:0] remain;
  logic       in_addr;
  logic       unused_adr_lo;

  // Lane offset comes from the decoder, so the byte offset of the Wishbone address is not needed.
  assign unused_adr_lo = ^wb_adr_i[1:0];

  ahbl_sel_decode #(
    .SPLIT_EN(SPLIT_EN)
  ) u_sel_decode (
    .mask_i    (mask_q),
    .hsize_o   (dec_hsize),
    .addr_lo_o (dec_lo),
    .consumed_o(dec_consumed)
  );

  assign remain = mask_q & ~dec_consumed;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    dat_d   = dat_q;
    mask_d  = mask_q;
    abort_d = abort_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d   = wb_adr_i[AW-1:2];
          we_d    = wb_we_i;
          dat_d   = wb_dat_i;
          abort_d = 1'b0;
          mask_d  = wb_we_i ? wb_sel_i : 4'b1111;
          if (wb_we_i && wb_sel_i == 4'b0000) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (HREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        // An abandoned cycle still finishes the beat on the bus, then drops the rest silently.
        if (HREADY) begin
          if (abort_q || !wb_cyc_i) begin
            mask_d  = '0;
            state_d = ST_IDLE;
          end else begin
            mask_d = remain;
            if (!we_q) rdat_d = HRDATA;
            if (remain != 4'b0000) begin
              state_d = ST_ADDR;
            end else begin
              state_d = ST_ACK;
              ack_d   = 1'b1;
            end
          end
        end
      end
      ST_ACK: begin
        mask_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      mask_q  <= '0;
      abort_q <= 1'b0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      mask_q  <= mask_d;
      abort_q <= abort_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
    end
  end

  assign in_addr  = (state_q == ST_ADDR);
  assign HSEL     = in_addr;
  assign HTRANS   = in_addr ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR    = in_addr ? {adr_q, dec_lo} : '0;
  assign HSIZE    = in_addr ? dec_hsize : HSIZE_WORD;
  assign HWRITE   = in_addr & we_q;
  assign HWDATA   = (state_q == ST_DATA) ? dat_q : '0;
  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;

endmodule
